// File: rtl/eng_outbuf.sv
// Engine output buffer: DEPTH-entry FIFO of full parity results, serialized one packet per cycle.
// Optional overflow check enabled by defining OUTBUF_OVF_CHK_EN.
module eng_outbuf #(
  parameter int PACKET_LENGTH          = 32,
  parameter int W                      = 8,
  parameter int PCK_TREE_XOR_UNITS_NUM = 2,
  parameter int DEPTH                  = 4,
  localparam int N                     = PCK_TREE_XOR_UNITS_NUM * W,
  localparam int IW                    = $clog2(N)
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       eng_rstn,
  input  logic                       eng_outbuf_wr_req,
  input  logic [N*PACKET_LENGTH-1:0] eng_outbuf_din,
  output logic                       outbuf_eng_wr_ack,
  output logic                       outbuf_eng_full,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PACKET_LENGTH-1:0]   out_data,
  output logic [IW-1:0]              out_idx,
  output logic                       out_last,
  output logic                       outbuf_empty,
  output logic                       outbuf_ovf_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] pkt_idx_q, pkt_idx_d;
  logic [N*PACKET_LENGTH-1:0] mem_q [DEPTH];
  logic [N*PACKET_LENGTH-1:0] head_s;

  logic full_s, empty_s, wr_en_s, rd_fire_s, last_s, pop_s;

  assign full_s    = (count_q == CW'(DEPTH));
  assign empty_s   = (count_q == {CW{1'b0}});
  assign wr_en_s   = eng_outbuf_wr_req & ~full_s & eng_rstn;
  assign last_s    = (pkt_idx_q == IW'(N - 1));
  assign rd_fire_s = ~empty_s & out_ready;
  assign pop_s     = rd_fire_s & last_s;

  // Next-state for pointers, occupancy and packet index; engine flush has priority
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    pkt_idx_d = pkt_idx_q;
    if (!eng_rstn) begin
      wr_ptr_d  = {AW{1'b0}};
      rd_ptr_d  = {AW{1'b0}};
      count_d   = {CW{1'b0}};
      pkt_idx_d = {IW{1'b0}};
    end else begin
      if (wr_en_s) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d  = rd_ptr_q + AW'(1);
        pkt_idx_d = {IW{1'b0}};
      end else if (rd_fire_s) begin
        pkt_idx_d = pkt_idx_q + IW'(1);
      end else begin
        pkt_idx_d = pkt_idx_q;
      end
      count_d = count_q + CW'(wr_en_s) - CW'(pop_s);
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q  <= {AW{1'b0}};
      rd_ptr_q  <= {AW{1'b0}};
      count_q   <= {CW{1'b0}};
      pkt_idx_q <= {IW{1'b0}};
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pkt_idx_q <= pkt_idx_d;
    end
  end

  // Entry storage; contents deliberately survive both resets
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= eng_outbuf_din;
    end
  end

  assign head_s = mem_q[rd_ptr_q];

  // Data is masked while empty so stale storage never shows on the bus
  assign out_data          = empty_s ? {PACKET_LENGTH{1'b0}} : head_s[pkt_idx_q*PACKET_LENGTH +: PACKET_LENGTH];
  assign out_idx           = pkt_idx_q;
  assign out_last          = last_s;
  assign out_valid         = ~empty_s;
  assign outbuf_empty      = empty_s;
  assign outbuf_eng_full   = full_s;
  assign outbuf_eng_wr_ack = wr_en_s;

`ifdef OUTBUF_OVF_CHK_EN
  logic ovf_q, ovf_d;

  // Sticky overflow: a request arriving while full is dropped and flagged
  always_comb begin
    ovf_d = ovf_q;
    if (!eng_rstn) begin
      ovf_d = 1'b0;
    end else if (eng_outbuf_wr_req && full_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Overflow flag register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign outbuf_ovf_err = ovf_q;
`else
  assign outbuf_ovf_err = 1'b0;
`endif

endmodule
